cache_ctrl_2way: RTL and testbench

Two-way set-associative, write-back, write-allocate cache controller. Generalises the direct-mapped controller in line size, index width and memory latency. Sits between the system memory interface (Rd/Wr/Addr) and two cache-way arrays plus the pipelined multi-bank main memory. Selects victims with a pseudo-LRU toggle and tolerates memory back-pressure.

---
 rtl/cache_ctrl_2way.sv | 219 +++++++++++++++++++++
 tb/tb_cache_ctrl_2way.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_2way.sv
// Two-way set-associative write-back/write-allocate cache controller with toggle pseudo-LRU victim.
// Hit: Done 1 cycle after accept; miss: +WORDS+MEM_LAT+1 (+WORDS if dirty); mem_stall holds the current memory beat.
module cache_ctrl_2way #(
  parameter int ADDR_W  = 16,
  parameter int INDEX_W = 8,
  parameter int WORDS   = 4,
  parameter int MEM_LAT = 2,
  localparam int BEAT_W = $clog2(WORDS),
  localparam int OFF_W  = BEAT_W + 1,
  localparam int TAG_W  = ADDR_W - INDEX_W - OFF_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  Addr,
  input  logic [ADDR_W-1:0]  DataIn,
  input  logic               Rd,
  input  logic               Wr,
  output logic [ADDR_W-1:0]  DataOut,
  output logic               Done,
  output logic               CacheHit,
  output logic               Stall_sys,
  output logic               Err,
  input  logic               hit0,
  input  logic               hit1,
  input  logic               valid0,
  input  logic               valid1,
  input  logic               dirty0,
  input  logic               dirty1,
  input  logic [TAG_W-1:0]   tag_out0,
  input  logic [TAG_W-1:0]   tag_out1,
  input  logic [ADDR_W-1:0]  data_out0,
  input  logic [ADDR_W-1:0]  data_out1,
  output logic               enable0,
  output logic               enable1,
  output logic               cmp,
  output logic               write,
  output logic               valid_in,
  output logic [INDEX_W-1:0] index,
  output logic [OFF_W-1:0]   offset,
  output logic [TAG_W-1:0]   tag,
  output logic [ADDR_W-1:0]  data_in,
  output logic [ADDR_W-1:0]  addr_mem,
  output logic [ADDR_W-1:0]  data_in_mem,
  output logic               wr_mem,
  output logic               rd_mem,
  input  logic [ADDR_W-1:0]  data_out_mem,
  input  logic               mem_stall
);
  localparam int CNT_W = BEAT_W + 1;

  typedef enum logic [2:0] {IDLE, COMPARE, WB, FILL, RETRY} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0] req_addr, req_data;
  logic              req_wr;
  logic              victimway, victim;
  logic [BEAT_W-1:0] beat;
  logic [CNT_W-1:0]  icnt, wcnt;
  logic [MEM_LAT-1:0] tok;

  logic [INDEX_W-1:0] req_index;
  logic [TAG_W-1:0]   req_tag;
  logic [OFF_W-1:0]   req_off;
  assign req_index = req_addr[ADDR_W-1 -: INDEX_W];
  assign req_tag   = req_addr[OFF_W +: TAG_W];
  assign req_off   = req_addr[OFF_W-1:0];

  logic req_ok, req_bad, way0_hit, way1_hit, miss_victim, miss_dirty;
  assign req_ok   = (Rd ^ Wr) & ~Addr[0];
  assign req_bad  = (Rd & Wr) | ((Rd | Wr) & Addr[0]);
  assign way0_hit = hit0 & valid0;
  assign way1_hit = hit1 & valid1;
  // Fill an empty way before evicting; otherwise follow the toggle.
  assign miss_victim = !valid0 ? 1'b0 : (!valid1 ? 1'b1 : victimway);
  assign miss_dirty  = miss_victim ? (valid1 & dirty1) : (valid0 & dirty0);

  logic [TAG_W-1:0]  vic_tag;
  logic [ADDR_W-1:0] vic_data;
  assign vic_tag  = victim ? tag_out1 : tag_out0;
  assign vic_data = victim ? data_out1 : data_out0;

  logic issuing, issue_acc, tok_exit;
  assign issuing   = icnt < CNT_W'(WORDS);
  assign issue_acc = (state == FILL) && issuing && !mem_stall;
  assign tok_exit  = tok[MEM_LAT-1];

  assign Stall_sys = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    DataOut     = '0;
    Done        = 1'b0;
    CacheHit    = 1'b0;
    Err         = 1'b0;
    enable0     = 1'b0;
    enable1     = 1'b0;
    cmp         = 1'b0;
    write       = 1'b0;
    valid_in    = 1'b0;
    index       = '0;
    offset      = '0;
    tag         = '0;
    data_in     = '0;
    addr_mem    = '0;
    data_in_mem = '0;
    wr_mem      = 1'b0;
    rd_mem      = 1'b0;
    case (state)
      IDLE: begin
        if (req_ok) begin
          state_nxt = COMPARE;
        end else if (req_bad) begin
          Done = 1'b1;
          Err  = 1'b1;
        end
      end
      COMPARE: begin
        enable0 = 1'b1;
        enable1 = 1'b1;
        cmp     = 1'b1;
        write   = req_wr;
        index   = req_index;
        tag     = req_tag;
        offset  = req_off;
        data_in = req_data;
        if (way0_hit | way1_hit) begin
          Done      = 1'b1;
          CacheHit  = 1'b1;
          DataOut   = way0_hit ? data_out0 : data_out1;
          state_nxt = IDLE;
        end else begin
          state_nxt = miss_dirty ? WB : FILL;
        end
      end
      WB: begin
        enable0     = ~victim;
        enable1     = victim;
        index       = req_index;
        offset      = {beat, 1'b0};
        wr_mem      = 1'b1;
        addr_mem    = {req_index, vic_tag, beat, 1'b0};
        data_in_mem = vic_data;
        if (!mem_stall && beat == BEAT_W'(WORDS-1)) state_nxt = FILL;
      end
      FILL: begin
        index = req_index;
        tag   = req_tag;
        if (issuing) begin
          rd_mem   = 1'b1;
          addr_mem = {req_index, req_tag, icnt[BEAT_W-1:0], 1'b0};
        end
        // Returning data is written the cycle its token leaves the latency pipe.
        if (tok_exit) begin
          enable0  = ~victim;
          enable1  = victim;
          write    = 1'b1;
          valid_in = 1'b1;
          offset   = {wcnt[BEAT_W-1:0], 1'b0};
          data_in  = data_out_mem;
          if (wcnt == CNT_W'(WORDS-1)) state_nxt = RETRY;
        end
      end
      RETRY: begin
        enable0   = ~victim;
        enable1   = victim;
        cmp       = 1'b1;
        write     = req_wr;
        index     = req_index;
        tag       = req_tag;
        offset    = req_off;
        data_in   = req_data;
        Done      = 1'b1;
        DataOut   = vic_data;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_addr  <= '0;
      req_data  <= '0;
      req_wr    <= 1'b0;
      victimway <= 1'b0;
      victim    <= 1'b0;
      beat      <= '0;
      icnt      <= '0;
      wcnt      <= '0;
      tok       <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        req_addr <= Addr;
        req_data <= DataIn;
        req_wr   <= Wr;
      end
      if (state == COMPARE) begin
        victimway <= ~victimway;
        victim    <= miss_victim;
      end
      if (state == WB) begin
        if (!mem_stall) beat <= beat + BEAT_W'(1);
      end else begin
        beat <= '0;
      end
      if (state == FILL) begin
        if (issue_acc) icnt <= icnt + CNT_W'(1);
        if (tok_exit)  wcnt <= wcnt + CNT_W'(1);
        tok <= (tok << 1) | MEM_LAT'(issue_acc);
      end else begin
        icnt <= '0;
        wcnt <= '0;
        tok  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_cache_ctrl_2way.sv
// Directed bench for cache_ctrl_2way with behavioural way arrays and a 2-cycle pipelined memory.
module tb_cache_ctrl_2way;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Addr, DataIn, DataOut;
  logic        Rd, Wr, Done, CacheHit, Stall_sys, Err;
  logic        hit0, hit1, valid0, valid1, dirty0, dirty1;
  logic [4:0]  tag_out0, tag_out1, tag;
  logic [15:0] data_out0, data_out1, data_in;
  logic        enable0, enable1, cmp, write, valid_in;
  logic [7:0]  index;
  logic [2:0]  offset;
  logic [15:0] addr_mem, data_in_mem, data_out_mem;
  logic        wr_mem, rd_mem, mem_stall;

  always #5 clk = ~clk;

  cache_ctrl_2way dut (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .DataOut(DataOut), .Done(Done), .CacheHit(CacheHit), .Stall_sys(Stall_sys), .Err(Err),
    .hit0(hit0), .hit1(hit1), .valid0(valid0), .valid1(valid1), .dirty0(dirty0), .dirty1(dirty1),
    .tag_out0(tag_out0), .tag_out1(tag_out1), .data_out0(data_out0), .data_out1(data_out1),
    .enable0(enable0), .enable1(enable1), .cmp(cmp), .write(write), .valid_in(valid_in),
    .index(index), .offset(offset), .tag(tag), .data_in(data_in),
    .addr_mem(addr_mem), .data_in_mem(data_in_mem), .wr_mem(wr_mem), .rd_mem(rd_mem),
    .data_out_mem(data_out_mem), .mem_stall(mem_stall)
  );

  // Way arrays
  logic [4:0]  wtag [2][256];
  logic        wval [2][256];
  logic        wdty [2][256];
  logic [15:0] wdat [2][256][4];
  logic        clr_ways;
  int          nc_wr_cnt;

  assign tag_out0  = wtag[0][index];
  assign tag_out1  = wtag[1][index];
  assign valid0    = wval[0][index];
  assign valid1    = wval[1][index];
  assign dirty0    = wdty[0][index];
  assign dirty1    = wdty[1][index];
  assign data_out0 = wdat[0][index][offset[2:1]];
  assign data_out1 = wdat[1][index][offset[2:1]];
  assign hit0      = (wtag[0][index] == tag);
  assign hit1      = (wtag[1][index] == tag);

  always @(posedge clk) begin
    if (clr_ways) begin
      for (int w = 0; w < 2; w++)
        for (int i = 0; i < 256; i++) begin
          wval[w][i] <= 1'b0;
          wdty[w][i] <= 1'b0;
          wtag[w][i] <= 5'd0;
        end
    end else begin
      for (int w = 0; w < 2; w++)
        if ((w == 0 ? enable0 : enable1) && write) begin
          if (!cmp) begin
            wdat[w][index][offset[2:1]] <= data_in;
            wtag[w][index] <= tag;
            wval[w][index] <= valid_in;
            wdty[w][index] <= 1'b0;
            nc_wr_cnt <= nc_wr_cnt + 1;
          end else if (wval[w][index] && wtag[w][index] == tag) begin
            wdat[w][index][offset[2:1]] <= data_in;
            wdty[w][index] <= 1'b1;
          end
        end
    end
  end

  // Main memory: unwritten words read as addr ^ 16'h5A5A
  logic [15:0] memw [logic [15:0]];
  logic        p0v, p1v;
  logic [15:0] p0a, p1d;
  int          mem_wr_cnt, rd_cnt;
  logic [15:0] rd_hist [64];

  function automatic logic [15:0] memrd(input logic [15:0] a);
    if (memw.exists(a)) return memw[a];
    return a ^ 16'h5A5A;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      p0v <= 1'b0;
      p1v <= 1'b0;
    end else begin
      p0v <= rd_mem && !mem_stall;
      p1v <= p0v;
    end
    p0a <= addr_mem;
    p1d <= memrd(p0a);
    if (wr_mem && !mem_stall) begin
      memw[addr_mem] = data_in_mem;
      mem_wr_cnt <= mem_wr_cnt + 1;
    end
    if (rd_mem && !mem_stall) begin
      rd_hist[rd_cnt[5:0]] <= addr_mem;
      rd_cnt <= rd_cnt + 1;
    end
  end
  assign data_out_mem = p1v ? p1d : 16'h0;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", nm, obs, exp);
    end
  endtask

  int          lat;
  logic        g_done, g_err, g_hit, g_act, g_stall1;
  logic [15:0] g_dout;

  // Issue one request; mem_stall is high for cycles s0..s0+slen-1 after acceptance.
  task automatic req(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                     input int s0, input int slen);
    @(negedge clk);
    Rd = rd; Wr = wr; Addr = a; DataIn = d; mem_stall = 1'b0;
    #1;
    lat = 0;
    g_act = enable0 | enable1 | rd_mem | wr_mem;
    g_stall1 = 1'b0;
    if (!Done) begin
      @(negedge clk);
      Rd = 1'b0; Wr = 1'b0; lat = 1;
      mem_stall = (lat >= s0 && lat < s0 + slen);
      #1;
      g_stall1 = Stall_sys;
      while (!Done && lat < 100) begin
        @(negedge clk);
        lat++;
        mem_stall = (lat >= s0 && lat < s0 + slen);
        #1;
      end
    end
    g_done = Done; g_err = Err; g_hit = CacheHit; g_dout = DataOut;
    Rd = 1'b0; Wr = 1'b0; mem_stall = 1'b0;
  endtask

  int base_rd, base_wr, base_nc;

  initial begin
    rst = 1'b1; clr_ways = 1'b1;
    Rd = 1'b0; Wr = 1'b0; Addr = '0; DataIn = '0; mem_stall = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_done", Done, 0);
    chk("rst_hit", CacheHit, 0);
    chk("rst_err", Err, 0);
    chk("rst_stall", Stall_sys, 0);
    chk("rst_strobes", {enable0, enable1, cmp, write, valid_in, rd_mem, wr_mem}, 0);
    chk("rst_buses", {addr_mem, DataOut}, 0);
    @(negedge clk);
    rst = 1'b0; clr_ways = 1'b0;

    // Clean miss into empty way0
    base_rd = rd_cnt;
    req(1, 0, 16'h1208, 16'h0, 0, 0);
    chk("miss1_stall", g_stall1, 1);
    chk("miss1_lat", lat, 8);
    chk("miss1_hit", g_hit, 0);
    chk("miss1_data", g_dout, 16'h4852);
    chk("miss1_nrd", rd_cnt - base_rd, 4);
    chk("miss1_rd0", rd_hist[base_rd[5:0]], 16'h1208);
    chk("miss1_rd1", rd_hist[6'(base_rd + 1)], 16'h120A);
    chk("miss1_rd3", rd_hist[6'(base_rd + 3)], 16'h120E);

    req(1, 0, 16'h1208, 16'h0, 0, 0);
    chk("hit1_lat", lat, 1);
    chk("hit1_hit", g_hit, 1);
    chk("hit1_data", g_dout, 16'h4852);
    @(negedge clk); #1;
    chk("done_pulse", Done, 0);
    chk("idle_stall", Stall_sys, 0);

    req(0, 1, 16'h120A, 16'hBEEF, 0, 0);
    chk("whit_lat", lat, 1);
    chk("whit_hit", g_hit, 1);

    // Tag 2 fills empty way1
    req(1, 0, 16'h1210, 16'h0, 0, 0);
    chk("miss2_lat", lat, 8);
    chk("miss2_data", g_dout, 16'h484A);

    // Tag 3 evicts dirty way0
    base_wr = mem_wr_cnt;
    req(1, 0, 16'h1218, 16'h0, 0, 0);
    chk("dmiss_lat", lat, 12);
    chk("dmiss_hit", g_hit, 0);
    chk("dmiss_data", g_dout, 16'h4842);
    chk("dmiss_nwr", mem_wr_cnt - base_wr, 4);
    chk("wb_w0", memrd(16'h1208), 16'h4852);
    chk("wb_beef", memrd(16'h120A), 16'hBEEF);
    chk("wb_w3", memrd(16'h120E), 16'h4854);

    // Tag 4 evicts clean way1 with a 3-cycle stall on issue beat 1
    base_rd = rd_cnt; base_nc = nc_wr_cnt;
    req(1, 0, 16'h1220, 16'h0, 3, 3);
    chk("stall_lat", lat, 11);
    chk("stall_data", g_dout, 16'h487A);
    chk("stall_nrd", rd_cnt - base_rd, 4);
    chk("stall_ncw", nc_wr_cnt - base_nc, 4);
    chk("stall_rd1", rd_hist[6'(base_rd + 1)], 16'h1222);
    chk("stall_rd2", rd_hist[6'(base_rd + 2)], 16'h1224);
    chk("stall_word2", wdat[1][8'h12][2], 16'h487E);

    req(1, 0, 16'h1222, 16'h0, 0, 0);
    chk("hit2_lat", lat, 1);
    chk("hit2_data", g_dout, 16'h4878);

    // Illegal requests
    req(1, 0, 16'h0001, 16'h0, 0, 0);
    chk("odd_lat", lat, 0);
    chk("odd_done", g_done, 1);
    chk("odd_err", g_err, 1);
    chk("odd_act", g_act, 0);
    req(1, 1, 16'h1208, 16'h0, 0, 0);
    chk("rdwr_lat", lat, 0);
    chk("rdwr_err", g_err, 1);
    chk("rdwr_act", g_act, 0);
    @(negedge clk); #1;
    chk("err_pulse", Err, 0);

    // Dirty way0, then reset during write-back beat 2
    req(0, 1, 16'h1218, 16'h1234, 0, 0);
    chk("w3_hit", g_hit, 1);
    @(negedge clk);
    Rd = 1'b1; Addr = 16'h1228;
    @(negedge clk); Rd = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("wb2_wr", wr_mem, 1);
    chk("wb2_addr", addr_mem, 16'h121C);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("rstwb_wr", wr_mem, 0);
    chk("rstwb_stall", Stall_sys, 0);
    chk("rstwb_en", {enable0, enable1, rd_mem}, 0);
    rst = 1'b0;

    // Victim toggle restarted at way0, which still holds dirty tag 3
    req(1, 0, 16'h1238, 16'h0, 0, 0);
    chk("post_lat", lat, 12);
    chk("post_data", g_dout, 16'h4862);
    chk("post_wb0", memrd(16'h1218), 16'h1234);
    chk("post_wb3", memrd(16'h121E), 16'h4844);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
